// File: rtl/vga_cursor_scan_if.sv
// rtl/vga_cursor_scan_if.sv - cursor register inputs and video timing outputs of vga_cursor_scan
//   icrx/icry/ictl : cursor column, row and control byte from the cursor register block
//   ohs/ovs        : active-low horizontal / vertical sync
//   ode            : display enable, visible 640x480 area
//   ocol/orow      : character column / row, zero outside the visible area
//   ocursor/ocolor : cursor pixel flag and its colour index
interface vga_cursor_scan_if;
    logic [7:0] icrx;
    logic [7:0] icry;
    logic [7:0] ictl;
    logic       ohs;
    logic       ovs;
    logic       ode;
    logic [6:0] ocol;
    logic [4:0] orow;
    logic       ocursor;
    logic [3:0] ocolor;

    modport master (
        output icrx, icry, ictl,
        input  ohs, ovs, ode, ocol, orow, ocursor, ocolor
    );

    modport slave (
        input  icrx, icry, ictl,
        output ohs, ovs, ode, ocol, orow, ocursor, ocolor
    );
endinterface

// File: rtl/vga_cursor_scan.sv
// rtl/vga_cursor_scan.sv - 640x480@60 VGA timing generator with character-cell text cursor
//   Clk     : pixel clock, rising edge
//   Reset_H : synchronous active-high reset
//   bus     : vga_cursor_scan_if.slave (cursor register inputs, registered video outputs)
//   Macro VGA_CURSOR_BLOCK_EN : full 8x16 block cursor; undefined gives a two-line underline
module vga_cursor_scan (
    input  logic             Clk,
    input  logic             Reset_H,
    vga_cursor_scan_if.slave bus
);
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_FIRST = 10'd656;
    localparam logic [9:0] H_SYNC_LAST  = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_FIRST = 10'd490;
    localparam logic [9:0] V_SYNC_LAST  = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [7:0] SCRX_RESET = 8'h28;
    localparam logic [7:0] SCRY_RESET = 8'h14;
    localparam logic [7:0] SCTL_RESET = 8'hf2;

    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [5:0] frame_q, frame_d;
    logic [7:0] scrx_q, scrx_d;
    logic [7:0] scry_q, scry_d;
    logic [7:0] sctl_q, sctl_d;

    logic       ohs_q, ohs_d;
    logic       ovs_q, ovs_d;
    logic       ode_q, ode_d;
    logic [6:0] ocol_q, ocol_d;
    logic [4:0] orow_q, orow_d;
    logic       ocursor_q, ocursor_d;
    logic [3:0] ocolor_q, ocolor_d;

    logic line_end;
    logic frame_end;
    logic visible;
    logic mode_shown;
    logic scan_hit;
    logic cell_hit;
    logic cursor_hit;

    // Control bits [3:2] are carried in the shadow but have no function.
    logic unused_sctl_bits;
    assign unused_sctl_bits = ^sctl_q[3:2];

    always_comb begin : counter_next
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);

        hcnt_d = line_end ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end

        // Cursor registers are sampled only at the frame boundary so a frame
        // never shows a half-updated cursor.
        frame_d = frame_q;
        scrx_d  = scrx_q;
        scry_d  = scry_q;
        sctl_d  = sctl_q;
        if (frame_end) begin
            frame_d = frame_q + 6'd1;
            scrx_d  = bus.icrx;
            scry_d  = bus.icry;
            sctl_d  = bus.ictl;
        end
    end

    always_comb begin : pixel_decode
        visible = (hcnt_q < H_VISIBLE) && (vcnt_q < V_VISIBLE);

        case (sctl_q[1:0])
            MODE_SOLID: mode_shown = 1'b1;
            MODE_BLINK: mode_shown = ~frame_q[5];
            default:    mode_shown = 1'b0;
        endcase

`ifdef VGA_CURSOR_BLOCK_EN
        scan_hit = 1'b1;
`else
        // Scanlines 14 and 15 of the 16-line character cell.
        scan_hit = (vcnt_q[3:1] == 3'b111);
`endif

        // Zero-extended compare: out-of-range shadows (>=80 / >=30) never match.
        cell_hit   = ({1'b0, hcnt_q[9:3]} == scrx_q) && ({3'b000, vcnt_q[8:4]} == scry_q);
        cursor_hit = visible && cell_hit && mode_shown && scan_hit;

        ohs_d     = ~((hcnt_q >= H_SYNC_FIRST) && (hcnt_q <= H_SYNC_LAST));
        ovs_d     = ~((vcnt_q >= V_SYNC_FIRST) && (vcnt_q <= V_SYNC_LAST));
        ode_d     = visible;
        ocol_d    = visible ? hcnt_q[9:3] : 7'd0;
        orow_d    = visible ? vcnt_q[8:4] : 5'd0;
        ocursor_d = cursor_hit;
        ocolor_d  = cursor_hit ? sctl_q[7:4] : 4'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            frame_q   <= 6'd0;
            scrx_q    <= SCRX_RESET;
            scry_q    <= SCRY_RESET;
            sctl_q    <= SCTL_RESET;
            ohs_q     <= 1'b1;
            ovs_q     <= 1'b1;
            ode_q     <= 1'b0;
            ocol_q    <= 7'd0;
            orow_q    <= 5'd0;
            ocursor_q <= 1'b0;
            ocolor_q  <= 4'd0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            frame_q   <= frame_d;
            scrx_q    <= scrx_d;
            scry_q    <= scry_d;
            sctl_q    <= sctl_d;
            ohs_q     <= ohs_d;
            ovs_q     <= ovs_d;
            ode_q     <= ode_d;
            ocol_q    <= ocol_d;
            orow_q    <= orow_d;
            ocursor_q <= ocursor_d;
            ocolor_q  <= ocolor_d;
        end
    end

    assign bus.ohs     = ohs_q;
    assign bus.ovs     = ovs_q;
    assign bus.ode     = ode_q;
    assign bus.ocol    = ocol_q;
    assign bus.orow    = orow_q;
    assign bus.ocursor = ocursor_q;
    assign bus.ocolor  = ocolor_q;
endmodule

// File: doc/vga_cursor_scan.md
VGA_CURSOR_SCAN -- requirements
Module: vga_cursor_scan

Interface
REQ-001 Clk  input  1  pixel clock, 25 MHz nominal; all logic on rising edge.
REQ-002 Reset_H  input  1  synchronous, active-high reset.
REQ-003 icrx  input  8  cursor column from the cursor register block (ocrx).
REQ-004 icry  input  8  cursor row from the cursor register block (ocry).
REQ-005 ictl  input  8  control byte: [1:0] cursor mode, [7:4] cursor colour index, [3:2] ignored.
REQ-006 ohs  output  1  horizontal sync, active-low.
REQ-007 ovs  output  1  vertical sync, active-low.
REQ-008 ode  output  1  display enable, high in the visible 640x480 area.
REQ-009 ocol  output  7  character column 0-79 (hcnt[9:3]) in the visible area, else 0.
REQ-010 orow  output  5  character row 0-29 (vcnt[8:4]) in the visible area, else 0.
REQ-011 ocursor  output  1  high when the current pixel is a cursor pixel.
REQ-012 ocolor  output  4  cursor colour index, valid while ocursor=1, else 0.

Function
REQ-013 The block SHALL keep a 10-bit hcnt (0-799) and a 10-bit vcnt (0-524); hcnt increments every cycle and wraps 799->0, and vcnt increments on that wrap and wraps 524->0.
REQ-014 Horizontal timing SHALL be: visible 0-639, front porch 640-655, sync 656-751 (ohs=0), back porch 752-799.
REQ-015 Vertical timing SHALL be: visible 0-479, front porch 480-489, sync 490-491 (ovs=0), back porch 492-524.
REQ-016 All outputs SHALL be registered with 1 cycle latency: outputs at cycle k+1 reflect counter values at cycle k.
REQ-017 Shadow registers scrx, scry and sctl SHALL load icrx, icry and ictl only in the cycle where hcnt=799 and vcnt=524; input changes mid-frame SHALL NOT affect the current frame.
REQ-018 A 6-bit frame counter SHALL increment in the same end-of-frame cycle and wrap 63->0; blink phase = frame counter bit 5 (0=shown, 1=hidden).
REQ-019 Cursor mode sctl[1:0] SHALL be decoded as: 00=off, 01=solid, 10=blinking (shown only when blink phase = 0), 11=reserved, treated as off.
REQ-020 The cursor hit condition SHALL be: visible area AND hcnt[9:3]=scrx AND vcnt[8:4]=scry AND mode shown AND scanline condition (REQ-027/028).
REQ-021 If scrx>=80 or scry>=30, ocursor SHALL stay 0 for the whole frame, with no wrap or modulo.
REQ-022 ocolor SHALL equal sctl[7:4] when ocursor=1, else 0.
REQ-023 Outside the visible area, ode, ocursor and ocolor SHALL be 0, and ocol and orow SHALL be 0.

Reset
REQ-024 While Reset_H=1 at a clock edge: hcnt=0, vcnt=0, frame counter=0, scrx=8'h28, scry=8'h14, sctl=8'hf2.
REQ-025 After reset the outputs SHALL be ohs=1, ovs=1, ode=0, ocol=0, orow=0, ocursor=0, ocolor=0.
REQ-026 Reset asserted mid-line or mid-frame SHALL abort the frame immediately; the first cycle after release starts at hcnt=0, vcnt=0 using the reset shadow values.

Configuration
REQ-027 With VGA_CURSOR_BLOCK_EN defined, the scanline condition SHALL always be true (full 8x16 block cursor).
REQ-028 Without VGA_CURSOR_BLOCK_EN, the scanline condition SHALL be vcnt[3:0] in 14..15 (two-line underline cursor).

Verification
REQ-029 Release reset, run 420000 cycles -> ohs low exactly 96 cycles per 800; ovs low for 2 lines per 525; ode high 640x480 cycles per frame.
REQ-030 Reset defaults, underline build -> first frame: ocursor=1 at hcnt 320-327, vcnt 334-335 (1 cycle later), ocolor=4'hf; no cursor pixels elsewhere.
REQ-031 Set ictl=8'h31, icrx=0, icry=0 mid-frame -> current frame unchanged; next frame: cursor at col 0, row 0, ocolor=3, visible in every frame.
REQ-032 ictl=8'hf2 held for 64 frames -> cursor shown in frames 0-31, hidden in frames 32-63, shown again in frame 64.
REQ-033 Set icrx=80 or ictl[1:0]=2'b11 -> ocursor=0 for the entire following frame.
REQ-034 Assert Reset_H for 1 cycle at hcnt=400, vcnt=200 -> next-cycle outputs equal the reset values; hcnt and vcnt restart at 0; shadows return to 28/14/f2.
